// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit layout, ALU op encodings, bubble constant.
package pipe_pkg;
  localparam int CTRL_W        = 11;
  localparam int CTRL_REGDST   = 10;
  localparam int CTRL_JUMP     = 9;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUOP_HI = 5;
  localparam int CTRL_ALUOP_LO = 3;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluop_e;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
  } ctrl_t;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side inputs, flush/stall, EX-side registered outputs.
interface id_ex_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  import pipe_pkg::*;

  logic [CTRL_W-1:0]     id_ctrl;
  logic                  id_valid;
  logic [DATA_W-1:0]     id_pc4, id_rd1, id_rd2, id_imm;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic                  flush;
  logic                  stall_out;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output id_ctrl, id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    input  stall_out, ex_ctrl, ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
           bubble_cnt
  );

  modport slave (
    input  id_ctrl, id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    output stall_out, ex_ctrl, ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
           bubble_cnt
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a valid load in EX whose rt feeds the valid ID instruction.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  output logic                  o_hazard
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign o_hazard = i_ex_valid & i_ex_mem_read & i_id_valid & (i_ex_rt != '0) &
                    ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, load-use stall and bubble counter.
// Optional hazard detection enabled by defining ID_EX_HAZARD_DETECT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);
  logic [CTRL_W-1:0]     r_ctrl;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc4, r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_hazard, w_bubble, w_count;

`ifdef ID_EX_HAZARD_DETECT_EN
  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl[CTRL_MEMREAD]),
    .i_id_valid    (bus.id_valid),
    .i_ex_rt       (r_rt),
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .o_hazard      (w_hazard)
  );
`else
  assign w_hazard = 1'b0;
`endif

  // flush wins: the ID instruction is dead, so there is nothing to hold
  assign bus.stall_out = w_hazard & ~bus.flush;
  assign w_bubble      = bus.flush | w_hazard | ~bus.id_valid;
  assign w_count       = bus.flush | w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (w_bubble) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else begin
      r_ctrl  <= bus.id_ctrl;
      r_valid <= bus.id_valid;
      r_pc4   <= bus.id_pc4;
      r_rd1   <= bus.id_rd1;
      r_rd2   <= bus.id_rd2;
      r_imm   <= bus.id_imm;
      r_rs    <= bus.id_rs;
      r_rt    <= bus.id_rt;
      r_rd    <= bus.id_rd;
    end
  end

  // Empty-slot bubbles are not counted; the counter saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (w_count && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.ex_ctrl    = r_ctrl;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_pc4     = r_pc4;
  assign bus.ex_rd1     = r_rd1;
  assign bus.ex_rd2     = r_rd2;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_rs      = r_rs;
  assign bus.ex_rt      = r_rt;
  assign bus.ex_rd      = r_rd;
  assign bus.bubble_cnt = r_cnt;
endmodule
